// File: rtl/e_mdu.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div with a countdown Busy phase,
// plus single-cycle mthi/mtlo and combinational mfhi/mflo read-out.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_Result
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMfhi  = 4'd7;
  localparam logic [3:0] OpMflo  = 4'd8;

  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_nz, b_mag_nz;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        is_div, b_zero;

  assign Start = (MDU_op >= OpMult) && (MDU_op <= OpDivu);
  assign Busy  = (cnt_q != '0);
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    MDU_Result = 32'd0;
    if (MDU_op == OpMfhi) MDU_Result = hi_q;
    else if (MDU_op == OpMflo) MDU_Result = lo_q;
  end

  // Signed division via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    prod_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u   = {32'd0, A} * {32'd0, B};
    b_zero   = (B == 32'd0);
    is_div   = (MDU_op == OpDiv) || (MDU_op == OpDivu);
    a_mag    = A[31] ? (32'd0 - A) : A;
    b_mag    = B[31] ? (32'd0 - B) : B;
    b_nz     = b_zero ? 32'd1 : B;
    b_mag_nz = b_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_mag_nz;
    r_mag    = a_mag % b_mag_nz;
    q_s      = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s      = A[31] ? (32'd0 - r_mag) : r_mag;
    q_u      = A / b_nz;
    r_u      = A % b_nz;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    cnt_d     = cnt_q;
    if (cnt_q != '0) begin
      // In-flight: Req and new ops are ignored; commit on the 1->0 edge.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && pend_we_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!Req) begin
      unique case (MDU_op)
        OpMult: begin
          cnt_d = CntW'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = prod_s;
        end
        OpMultu: begin
          cnt_d = CntW'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = prod_u;
        end
        OpDiv: begin
          cnt_d     = CntW'(DIV_CYCLES);
          pend_hi_d = r_s;
          pend_lo_d = q_s;
        end
        OpDivu: begin
          cnt_d     = CntW'(DIV_CYCLES);
          pend_hi_d = r_u;
          pend_lo_d = q_u;
        end
        OpMthi:  hi_d = A;
        OpMtlo:  lo_d = A;
        default: ;
      endcase
      if (Start) pend_we_d = !(is_div && b_zero);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: multiply/divide results, Busy length,
// flush suppression, divide-by-zero and mid-operation reset.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset, Req;
  logic [3:0]  MDU_op;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDU_Result;

  int tests = 0;
  int fails = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .Req        (Req),
    .MDU_op     (MDU_op),
    .A          (A),
    .B          (B),
    .Start      (Start),
    .Busy       (Busy),
    .HI         (HI),
    .LO         (LO),
    .MDU_Result (MDU_Result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an op, then confirm Busy holds for n cycles and drops with the commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string tag);
    MDU_op = op; A = a; B = b;
    tick();
    MDU_op = 4'd0;
    chk({tag, "_busy_c1"}, {31'd0, Busy}, 32'd1);
    for (int i = 1; i < n; i++) begin
      tick();
      if (i == n - 1) chk({tag, "_busy_last"}, {31'd0, Busy}, 32'd1);
    end
    tick();
    chk({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; MDU_op = 4'd0; A = 32'd0; B = 32'd0;
    tick();
    reset = 1'b0;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);

    MDU_op = 4'd1; #1;
    chk("start_mult", {31'd0, Start}, 32'd1);
    MDU_op = 4'd9; #1;
    chk("start_op9", {31'd0, Start}, 32'd0);
    MDU_op = 4'd0;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, "mult");
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, 5, "multu");
    chk("multu_hi", HI, 32'h0000_0002);
    chk("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, "div");
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, "divovf");
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0000_0000);

    MDU_op = 4'd5; A = 32'h1111_1111; tick();
    chk("mthi", HI, 32'h1111_1111);
    MDU_op = 4'd6; A = 32'h2222_2222; tick();
    chk("mtlo", LO, 32'h2222_2222);
    MDU_op = 4'd7; #1;
    chk("mfhi", MDU_Result, 32'h1111_1111);
    MDU_op = 4'd8; #1;
    chk("mflo", MDU_Result, 32'h2222_2222);
    MDU_op = 4'd0; #1;
    chk("mf_none", MDU_Result, 32'd0);

    run_op(4'd4, 32'd5, 32'd0, 10, "divu0");
    chk("divu0_hi", HI, 32'h1111_1111);
    chk("divu0_lo", LO, 32'h2222_2222);

    run_op(4'd4, 32'd100, 32'd7, 10, "divu");
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    Req = 1'b1; MDU_op = 4'd5; A = 32'h0000_1234; tick();
    chk("mthi_req", HI, 32'd2);
    MDU_op = 4'd1; A = 32'd3; B = 32'd3; tick();
    chk("start_req_busy", {31'd0, Busy}, 32'd0);
    Req = 1'b0; MDU_op = 4'd0;

    // Mult with flush in cycle 3, a blocked mtlo throughout, and Req on the final edge.
    MDU_op = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3; tick();
    MDU_op = 4'd6; A = 32'h0000_DEAD;
    tick();
    Req = 1'b1; tick();
    chk("req_c3_busy", {31'd0, Busy}, 32'd1);
    Req = 1'b0; tick(); tick();
    chk("req_c5_lo_old", LO, 32'd14);
    Req = 1'b1; tick();
    Req = 1'b0; MDU_op = 4'd0;
    chk("req_commit_busy", {31'd0, Busy}, 32'd0);
    chk("req_commit_hi", HI, 32'hFFFF_FFFF);
    chk("req_commit_lo", LO, 32'hFFFF_FFFA);

    // Reset in cycle 4 of a div also beats a concurrent mthi.
    MDU_op = 4'd3; A = 32'd100; B = 32'd7; tick();
    MDU_op = 4'd0;
    tick(); tick(); tick();
    reset = 1'b1; MDU_op = 4'd5; A = 32'h5555_5555; tick();
    reset = 1'b0; MDU_op = 4'd0;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'd0);
    chk("rst_mid_lo", LO, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("rst_nocommit_hi", HI, 32'd0);
    chk("rst_nocommit_lo", LO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
